// File: rtl/rdyack_packer.sv
// Packs NPACK consecutive BW-bit rdy/ack beats into one wide word; a beat with
// i_last closes the group early and yields a partial word (first beat in LSBs).
module rdyack_packer #(
  parameter int BW    = 8,
  parameter int NPACK = 4
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic                         src_rdy,
  output logic                         src_ack,
  input  logic [BW-1:0]                i_data,
  input  logic                         i_last,
  output logic                         dst_rdy,
  input  logic                         dst_ack,
  output logic [NPACK*BW-1:0]          o_data,
  output logic [$clog2(NPACK+1)-1:0]   o_cnt,
  output logic                         o_last
);

  localparam int CW = $clog2(NPACK + 1);

  if (NPACK < 2) begin : g_bad_npack
    $error("rdyack_packer: NPACK must be >= 2");
  end

  logic [(NPACK-1)*BW-1:0] acc_q, acc_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic                    dst_rdy_q;
  logic [NPACK*BW-1:0]     o_data_q;
  logic [CW-1:0]           o_cnt_q;
  logic                    o_last_q;

  logic                    completing;
  logic                    out_free;
  logic [NPACK*BW-1:0]     pack_word;

  assign completing = src_rdy && ((cnt_q == CW'(NPACK - 1)) || i_last);
  assign out_free   = !dst_rdy_q || dst_ack;
  // Non-completing beats never touch the output register, so they are never stalled.
  assign src_ack    = src_rdy && (!completing || out_free);

  // Word presented on a completing beat: held lanes below cnt_q, the new beat
  // at lane cnt_q, zeros above.
  for (genvar gi = 0; gi < NPACK; gi++) begin : g_lane
    if (gi < NPACK - 1) begin : g_acc_lane
      assign pack_word[gi*BW +: BW] =
        (CW'(gi) <  cnt_q) ? acc_q[gi*BW +: BW] :
        (CW'(gi) == cnt_q) ? i_data             : '0;
    end else begin : g_top_lane
      assign pack_word[gi*BW +: BW] = (cnt_q == CW'(gi)) ? i_data : '0;
    end
  end

  always_comb begin
    acc_d = acc_q;
    cnt_d = cnt_q;
    if (src_ack) begin
      if (completing) begin
        acc_d = '0;
        cnt_d = '0;
      end else begin
        acc_d[cnt_q*BW +: BW] = i_data;
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      dst_rdy_q <= 1'b0;
      o_data_q  <= '0;
      o_cnt_q   <= '0;
      o_last_q  <= 1'b0;
    end else begin
      acc_q <= acc_d;
      cnt_q <= cnt_d;
      if (src_ack && completing) begin
        o_data_q  <= pack_word;
        o_cnt_q   <= cnt_q + CW'(1);
        o_last_q  <= i_last;
        dst_rdy_q <= 1'b1;
      end else if (dst_rdy_q && dst_ack) begin
        dst_rdy_q <= 1'b0;
      end
    end
  end

  assign dst_rdy = dst_rdy_q;
  assign o_data  = o_data_q;
  assign o_cnt   = o_cnt_q;
  assign o_last  = o_last_q;

endmodule
